// File: rtl/tlc_monitor.sv
// tlc_monitor: lamp driver and run-time checker downstream of the TLC.
// Optional TLC_MON_SAFE_RED_EN forces all-red lamps while any error flag is set.
module tlc_monitor #(
    parameter int GREEN_T  = 8,
    parameter int YELLOW_T = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  ps_state,
    input  logic [3:0]  count,
    input  logic        clr,
    output logic [2:0]  ns_lamp,
    output logic [2:0]  ew_lamp,
    output logic        locked,
    output logic        err_seq,
    output logic        err_dwell,
    output logic        err_count,
    output logic [7:0]  viol_cnt,
    output logic [15:0] cycle_cnt
);

    typedef enum logic {SYNC, RUN} fsm_e;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    fsm_e        fsm_q, fsm_d;
    logic [1:0]  prev_state_q, prev_state_d;
    logic [3:0]  prev_count_q, prev_count_d;
    logic [4:0]  dw_q, dw_d;
    logic        seq_q, seq_d;
    logic        dwl_q, dwl_d;
    logic        cnt_q, cnt_d;
    logic [7:0]  viol_q, viol_d;
    logic [15:0] cyc_q, cyc_d;
    logic [2:0]  ns_q, ns_d;
    logic [2:0]  ew_q, ew_d;

    logic        seq_n, dwl_n, cnt_n, cyc_inc, same;

    function automatic logic [4:0] dwell_t(input logic [1:0] s);
        return s[0] ? 5'(YELLOW_T) : 5'(GREEN_T);
    endfunction

    // Phase tracking, checks, sticky flags, counters and lamp decode.
    always_comb begin
        fsm_d        = fsm_q;
        dw_d         = dw_q;
        prev_state_d = ps_state;
        prev_count_d = count;
        seq_n        = 1'b0;
        dwl_n        = 1'b0;
        cnt_n        = 1'b0;
        cyc_inc      = 1'b0;
        same         = (ps_state == prev_state_q);

        unique case (fsm_q)
            SYNC: begin
                if (!same) begin
                    fsm_d = RUN;
                    dw_d  = 5'd1;
                end
            end
            RUN: begin
                if (same) begin
                    dw_d  = (dw_q == 5'd31) ? dw_q : dw_q + 5'd1;
                    cnt_n = (count != prev_count_q + 4'd1);
                    dwl_n = (dw_d == dwell_t(ps_state) + 5'd1);
                end else begin
                    seq_n   = (ps_state != prev_state_q + 2'd1);
                    // an overrun was already flagged when dw passed T
                    dwl_n   = (dw_q < dwell_t(prev_state_q));
                    cnt_n   = (count != 4'd0);
                    cyc_inc = !seq_n && (prev_state_q == 2'b11);
                    dw_d    = 5'd1;
                end
            end
            default: fsm_d = SYNC;
        endcase

        if (clr) begin
            seq_d  = 1'b0;
            dwl_d  = 1'b0;
            cnt_d  = 1'b0;
            viol_d = 8'd0;
            cyc_d  = 16'd0;
        end else begin
            seq_d  = seq_q | seq_n;
            dwl_d  = dwl_q | dwl_n;
            cnt_d  = cnt_q | cnt_n;
            viol_d = viol_q;
            if ((seq_n | dwl_n | cnt_n) && (viol_q != 8'hff))
                viol_d = viol_q + 8'd1;
            cyc_d  = cyc_inc ? cyc_q + 16'd1 : cyc_q;
        end

        ns_d = RED;
        ew_d = RED;
        if (fsm_d == RUN) begin
            unique case (1'b1)
                ps_state == 2'b00: ns_d = GRN;
                ps_state == 2'b01: ns_d = YEL;
                ps_state == 2'b10: ew_d = GRN;
                ps_state == 2'b11: ew_d = YEL;
                default: ;
            endcase
        end
`ifdef TLC_MON_SAFE_RED_EN
        if (seq_d | dwl_d | cnt_d) begin
            ns_d = RED;
            ew_d = RED;
        end
`endif
    end

    // State, history and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q        <= SYNC;
            prev_state_q <= 2'b00;
            prev_count_q <= 4'd0;
            dw_q         <= 5'd0;
            seq_q        <= 1'b0;
            dwl_q        <= 1'b0;
            cnt_q        <= 1'b0;
            viol_q       <= 8'd0;
            cyc_q        <= 16'd0;
            ns_q         <= RED;
            ew_q         <= RED;
        end else begin
            fsm_q        <= fsm_d;
            prev_state_q <= prev_state_d;
            prev_count_q <= prev_count_d;
            dw_q         <= dw_d;
            seq_q        <= seq_d;
            dwl_q        <= dwl_d;
            cnt_q        <= cnt_d;
            viol_q       <= viol_d;
            cyc_q        <= cyc_d;
            ns_q         <= ns_d;
            ew_q         <= ew_d;
        end
    end

    assign ns_lamp   = ns_q;
    assign ew_lamp   = ew_q;
    assign locked    = (fsm_q == RUN);
    assign err_seq   = seq_q;
    assign err_dwell = dwl_q;
    assign err_count = cnt_q;
    assign viol_cnt  = viol_q;
    assign cycle_cnt = cyc_q;

endmodule

// File: tb/tb_tlc_monitor.sv
// tb_tlc_monitor: directed and randomized checks of tlc_monitor against
// a phase-level reference model.
module tb_tlc_monitor;

    localparam int G = 8;
    localparam int Y = 3;

    logic        clk;
    logic        rst;
    logic [1:0]  ps_state;
    logic [3:0]  count;
    logic        clr;
    logic [2:0]  ns_lamp;
    logic [2:0]  ew_lamp;
    logic        locked;
    logic        err_seq;
    logic        err_dwell;
    logic        err_count;
    logic [7:0]  viol_cnt;
    logic [15:0] cycle_cnt;

    tlc_monitor #(.GREEN_T(G), .YELLOW_T(Y)) dut (
        .clk       (clk),
        .rst       (rst),
        .ps_state  (ps_state),
        .count     (count),
        .clr       (clr),
        .ns_lamp   (ns_lamp),
        .ew_lamp   (ew_lamp),
        .locked    (locked),
        .err_seq   (err_seq),
        .err_dwell (err_dwell),
        .err_count (err_count),
        .viol_cnt  (viol_cnt),
        .cycle_cnt (cycle_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_err = 0;

    // reference model: phase-level view of the monitor
    int m_locked, m_ps, m_pc, m_dw, m_viol, m_cyc;
    int m_seq, m_dwl, m_cnt;

    function automatic int tdw(input int s);
        return (s % 2 == 1) ? Y : G;
    endfunction

    task automatic model_reset();
        m_locked = 0; m_ps = 0; m_pc = 0; m_dw = 0;
        m_viol = 0; m_cyc = 0;
        m_seq = 0; m_dwl = 0; m_cnt = 0;
    endtask

    task automatic model(input int st, input int cn, input int c);
        int es, ed, ec;
        es = 0; ed = 0; ec = 0;
        if (m_locked == 0) begin
            if (st != m_ps) begin
                m_locked = 1;
                m_dw = 1;
            end
        end else if (st == m_ps) begin
            if (m_dw < 31) m_dw = m_dw + 1;
            ec = (cn != (m_pc + 1) % 16) ? 1 : 0;
            ed = (m_dw == tdw(st) + 1) ? 1 : 0;
        end else begin
            es = (st != (m_ps + 1) % 4) ? 1 : 0;
            ed = (m_dw < tdw(m_ps)) ? 1 : 0;
            ec = (cn != 0) ? 1 : 0;
            if (es == 0 && m_ps == 3) m_cyc = (m_cyc + 1) % 65536;
            m_dw = 1;
        end
        if (c != 0) begin
            m_seq = 0; m_dwl = 0; m_cnt = 0;
            m_viol = 0; m_cyc = 0;
        end else begin
            m_seq = m_seq | es;
            m_dwl = m_dwl | ed;
            m_cnt = m_cnt | ec;
            if ((es | ed | ec) != 0 && m_viol < 255) m_viol = m_viol + 1;
        end
        m_ps = st;
        m_pc = cn;
    endtask

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [2:0] ens, eew;
        ens = 3'b100;
        eew = 3'b100;
        if (m_locked != 0) begin
            case (m_ps)
                0: ens = 3'b001;
                1: ens = 3'b010;
                2: eew = 3'b001;
                default: eew = 3'b010;
            endcase
        end
`ifdef TLC_MON_SAFE_RED_EN
        if ((m_seq | m_dwl | m_cnt) != 0) begin
            ens = 3'b100;
            eew = 3'b100;
        end
`endif
        check({tag, ".ns"}, 16'(ns_lamp), 16'(ens));
        check({tag, ".ew"}, 16'(ew_lamp), 16'(eew));
        check({tag, ".locked"}, 16'(locked), 16'(m_locked));
        check({tag, ".err_seq"}, 16'(err_seq), 16'(m_seq));
        check({tag, ".err_dwell"}, 16'(err_dwell), 16'(m_dwl));
        check({tag, ".err_count"}, 16'(err_count), 16'(m_cnt));
        check({tag, ".viol"}, 16'(viol_cnt), 16'(m_viol));
        check({tag, ".cycle"}, cycle_cnt, 16'(m_cyc));
    endtask

    task automatic step(input logic [1:0] st, input logic [3:0] cn,
                        input logic c, input string tag);
        @(negedge clk);
        ps_state = st;
        count = cn;
        clr = c;
        @(posedge clk);
        model(int'(st), int'(cn), int'(c));
        #1 check_all(tag);
    endtask

    task automatic phase(input logic [1:0] st, input int n, input string tag);
        for (int i = 0; i < n; i++) step(st, 4'(i), 1'b0, tag);
    endtask

    initial begin
        logic [1:0] cur, nxt;
        int len;
        logic [3:0] cn;

        rst = 1'b1; ps_state = 2'b00; count = 4'd0; clr = 1'b0;
        #2 rst = 1'b0;
        #1 model_reset();
        check_all("reset");
        @(negedge clk);
        rst = 1'b1;

        // legal run, two full cycles then one NS green sample
        for (int k = 0; k < 2; k++) begin
            phase(2'b00, G, "legal");
            phase(2'b01, Y, "legal");
            phase(2'b10, G, "legal");
            phase(2'b11, Y, "legal");
        end
        phase(2'b00, 1, "legal");
        check("legal.cycle_cnt", cycle_cnt, 16'd2);
        check("legal.locked", 16'(locked), 16'd1);
        check("legal.viol", 16'(viol_cnt), 16'd0);

        // illegal jump 00 -> 10
        step(2'b10, 4'd0, 1'b0, "jump");
        check("jump.err_seq", 16'(err_seq), 16'd1);
        check("jump.viol", 16'(viol_cnt), 16'd1);
`ifdef TLC_MON_SAFE_RED_EN
        check("jump.ns", 16'(ns_lamp), 16'h4);
        check("jump.ew", 16'(ew_lamp), 16'h4);
`else
        check("jump.ns", 16'(ns_lamp), 16'h4);
        check("jump.ew", 16'(ew_lamp), 16'h1);
`endif
        step(2'b10, 4'd1, 1'b1, "clr1");
        check("clr1.err_seq", 16'(err_seq), 16'd0);

        // short green, then long yellow
        for (int i = 2; i < G; i++) step(2'b10, 4'(i), 1'b0, "fill");
        phase(2'b11, Y, "fill");
        phase(2'b00, 6, "short");
        step(2'b01, 4'd0, 1'b0, "short");
        check("short.err_dwell", 16'(err_dwell), 16'd1);
        step(2'b01, 4'd1, 1'b1, "clr2");
        step(2'b01, 4'd2, 1'b0, "long");
        check("long3.err_dwell", 16'(err_dwell), 16'd0);
        step(2'b01, 4'd3, 1'b0, "long");
        check("long4.err_dwell", 16'(err_dwell), 16'd1);
        step(2'b01, 4'd4, 1'b0, "long");
        check("long5.viol", 16'(viol_cnt), 16'd1);

        // count skip, then illegal transition with nonzero count
        step(2'b10, 4'd0, 1'b1, "clr3");
        step(2'b10, 4'd1, 1'b0, "skip");
        step(2'b10, 4'd2, 1'b0, "skip");
        step(2'b10, 4'd3, 1'b0, "skip");
        step(2'b10, 4'd5, 1'b0, "skip");
        check("skip.err_count", 16'(err_count), 16'd1);
        check("skip.viol", 16'(viol_cnt), 16'd1);
        step(2'b00, 4'd7, 1'b0, "multi");
        check("multi.err_seq", 16'(err_seq), 16'd1);
        check("multi.viol", 16'(viol_cnt), 16'd2);

        // saturation, then clear coinciding with an error
        repeat (300) step(2'b00, 4'd7, 1'b0, "sat");
        check("sat.viol", 16'(viol_cnt), 16'd255);
        step(2'b00, 4'd7, 1'b1, "clrerr");
        check("clrerr.flags", 16'({err_seq, err_dwell, err_count}), 16'd0);
        check("clrerr.viol", 16'(viol_cnt), 16'd0);
        check("clrerr.locked", 16'(locked), 16'd1);
        step(2'b00, 4'd8, 1'b0, "post");

        // randomized controller-like stream
        cur = 2'b00;
        for (int p = 0; p < 60; p++) begin
            nxt = ($urandom_range(0, 9) == 0) ? 2'($urandom) : cur + 2'd1;
            len = tdw(int'(nxt));
            if ($urandom_range(0, 4) == 0) len = $urandom_range(1, 20);
            for (int i = 0; i < len; i++) begin
                cn = 4'(i);
                if ($urandom_range(0, 19) == 0) cn = 4'($urandom);
                step(nxt, cn, 1'($urandom_range(0, 19) == 0), "rand");
            end
            cur = nxt;
        end

        // mid-phase asynchronous reset during EW green
        step(2'b10, 4'd0, 1'b0, "ewg");
        step(2'b10, 4'd1, 1'b0, "ewg");
        step(2'b10, 4'd2, 1'b0, "ewg");
        @(negedge clk);
        #2 rst = 1'b0;
        #1 model_reset();
        check_all("arst");
        check("arst.locked", 16'(locked), 16'd0);
        check("arst.ns", 16'(ns_lamp), 16'h4);
        @(negedge clk);
        rst = 1'b1;
        step(2'b10, 4'd3, 1'b0, "relock");
        check("relock.locked", 16'(locked), 16'd1);
        step(2'b10, 4'd4, 1'b0, "relock");
        phase(2'b11, Y, "relock");
        phase(2'b00, 2, "relock");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
